uart_tx_engine: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_bit_timer.sv | 26 ++
 rtl/uart_tx_engine.sv | 90 +++++++++
 tb/tb_uart_tx_engine.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry, baud counter width, standard-rate bit times
// and the transmit engine state encoding.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned BAUD_W     = 19;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    // Clocks per bit for the standard rates at SYS_CLK_HZ
    localparam logic [BAUD_W-1:0] BAUD_K_9600   = BAUD_W'(SYS_CLK_HZ / 9600);
    localparam logic [BAUD_W-1:0] BAUD_K_19200  = BAUD_W'(SYS_CLK_HZ / 19200);
    localparam logic [BAUD_W-1:0] BAUD_K_38400  = BAUD_W'(SYS_CLK_HZ / 38400);
    localparam logic [BAUD_W-1:0] BAUD_K_57600  = BAUD_W'(SYS_CLK_HZ / 57600);
    localparam logic [BAUD_W-1:0] BAUD_K_115200 = BAUD_W'(SYS_CLK_HZ / 115200);

    // Encoding is the (doit, load_d1) pair
    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_SHIFT = 2'b10,
        TX_LOAD  = 2'b11
    } tx_state_e;

    // Clock count for one bit; a programmed 0 behaves as 1
    function automatic logic [BAUD_W-1:0] clamp_baud_k(input logic [BAUD_W-1:0] k);
        return (k == '0) ? BAUD_W'(1) : k;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: runs while enabled and pulses btu_c on the last clock of each bit.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [BAUD_W-1:0] k_lat,
    output logic              btu_c
);

    logic [BAUD_W-1:0] timer_q;

    assign btu_c = run && (timer_q == (k_lat - BAUD_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (!run || btu_c) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches a byte for the parity/stop decoder, builds the
// 11-bit-time frame and shifts it out LSB-first at the latched bit time.
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              bit_10,
    input  logic              bit_9,
    output logic [7:0]        ldata,
    output logic              tx,
    output logic              txrdy
);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [FRAME_BITS-1:0] sr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [BAUD_W-1:0]     k_lat_q;
    logic                  accept_c;
    logic                  run_c;
    logic                  btu_c;
    logic                  done_c;

    assign accept_c = load && txrdy;
    assign run_c    = (state_q == TX_SHIFT);
    assign done_c   = btu_c && (cnt_q == CNT_W'(FRAME_BITS - 1));
    assign tx       = sr_q[0];

    uart_bit_timer u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run_c),
        .k_lat   (k_lat_q),
        .btu_c   (btu_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (accept_c) state_d = TX_LOAD;
            TX_LOAD:  state_d = TX_SHIFT;
            TX_SHIFT: if (done_c) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Start bit sits at the bottom so tx falls on the load cycle; the top 1 is the
    // trailing fill bit, and every shift back-fills with 1 so the line ends idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '1;
            txrdy   <= 1'b1;
            ldata   <= '0;
            cnt_q   <= '0;
            k_lat_q <= BAUD_W'(1);
        end else begin
            if (accept_c) begin
                ldata   <= out_port;
                k_lat_q <= clamp_baud_k(baud_k);
                txrdy   <= 1'b0;
            end

            if (state_q == TX_LOAD) begin
                sr_q <= {1'b1, bit_10, bit_9, ldata[6:0], 1'b0};
            end else if (btu_c) begin
                sr_q <= {1'b1, sr_q[FRAME_BITS-1:1]};
            end

            if (done_c) begin
                cnt_q <= '0;
                txrdy <= 1'b1;
            end else if (btu_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with a behavioural parity/stop decoder alongside.
module tb_uart_tx_engine;
    import uart_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              load;
    logic [7:0]        out_port;
    logic [BAUD_W-1:0] baud_k;
    logic              bit_10;
    logic              bit_9;
    logic [7:0]        ldata;
    logic              tx;
    logic              txrdy;
    logic              mode7;

    int checks = 0;
    int errors = 0;

    // 8N1: bit_9 = ldata[7]; 7E1: bit_9 = even parity of ldata[6:0]; bit_10 is the stop
    assign bit_10 = 1'b1;
    assign bit_9  = mode7 ? ^ldata[6:0] : ldata[7];

    uart_tx_engine dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .out_port (out_port),
        .baud_k   (baud_k),
        .bit_10   (bit_10),
        .bit_9    (bit_9),
        .ldata    (ldata),
        .tx       (tx),
        .txrdy    (txrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load one byte and check every clock of its frame; exp[i] is bit time i (0 = start).
    // A non-negative inj fires a load of 0xFF (and a new baud_k) at that clock of the frame.
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input logic [BAUD_W-1:0] bk, input int k,
                              input logic [10:0] exp, input int inj);
        out_port = d;
        baud_k   = bk;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk({tag, "_accept_txrdy"}, 32'(txrdy), 32'd0);
        chk({tag, "_accept_ldata"}, 32'(ldata), 32'(d));
        chk({tag, "_accept_tx"}, 32'(tx), 32'd1);
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < k; c++) begin
                if (i * k + c == inj) begin
                    load     = 1'b1;
                    out_port = 8'hFF;
                    baud_k   = 19'd7;
                end else begin
                    load = 1'b0;
                end
                tick();
                chk($sformatf("%s_bit%0d_c%0d_tx", tag, i, c), 32'(tx), 32'(exp[i]));
                chk($sformatf("%s_bit%0d_c%0d_txrdy", tag, i, c), 32'(txrdy), 32'd0);
            end
        end
        load = 1'b0;
        tick();
        chk({tag, "_end_txrdy"}, 32'(txrdy), 32'd1);
        chk({tag, "_end_tx"}, 32'(tx), 32'd1);
        chk({tag, "_end_ldata"}, 32'(ldata), 32'(d));
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        out_port = 8'h00;
        baud_k   = '0;
        mode7    = 1'b0;

        repeat (2) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_txrdy", 32'(txrdy), 32'd1);
        chk("rst_ldata", 32'(ldata), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_txrdy", 32'(txrdy), 32'd1);
        chk("idle_ldata", 32'(ldata), 32'd0);

        // 8N1 0x55, 4 clocks per bit
        send_frame("n81_55", 8'h55, 19'd4, 4, 11'h6AA, -1);

        // 7E1 0x03, 2 clocks per bit: parity 0
        mode7 = 1'b1;
        send_frame("e71_03", 8'h03, 19'd2, 2, 11'h606, -1);
        mode7 = 1'b0;

        // Load attempt and baud change mid-frame are ignored
        send_frame("n81_a5_ign", 8'hA5, 19'd3, 3, 11'h74A, 10);

        // Reset during bit 4
        out_port = 8'h55;
        baud_k   = 19'd4;
        load     = 1'b1;
        tick();
        load = 1'b0;
        repeat (1 + 4 * 4 + 1) tick();
        chk("midrst_pre_tx", 32'(tx), 32'd0);
        chk("midrst_pre_txrdy", 32'(txrdy), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_txrdy", 32'(txrdy), 32'd1);
        chk("midrst_ldata", 32'(ldata), 32'd0);
        tick();
        chk("midrst_hold_tx", 32'(tx), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        send_frame("postrst_55", 8'h55, 19'd4, 4, 11'h6AA, -1);

        // baud_k = 0 behaves as 1; second load on the first edge after txrdy rises
        send_frame("b2b_81", 8'h81, 19'd0, 1, 11'h702, -1);
        send_frame("b2b_7e", 8'h7E, 19'd0, 1, 11'h6FC, -1);

        repeat (2) tick();
        chk("final_tx", 32'(tx), 32'd1);
        chk("final_txrdy", 32'(txrdy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
